// File: rtl/axi_read_arbiter.sv
// Read-channel controller for a 2-master/2-slave AXI interconnect: round-robin
// arbitration, address decode, registered mux strobes and a DECERR responder.
module axi_read_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 4,
    parameter bit RESET_PRIORITY = 1'b0
) (
    input  logic                  G_clk,
    input  logic                  G_reset,
    input  logic                  M0_ARVALID,
    input  logic [ADDR_WIDTH-1:0] M0_ARADDR,
    input  logic [LEN_WIDTH-1:0]  M0_ARLEN,
    input  logic                  M0_RREADY,
    input  logic                  M1_ARVALID,
    input  logic [ADDR_WIDTH-1:0] M1_ARADDR,
    input  logic [LEN_WIDTH-1:0]  M1_ARLEN,
    input  logic                  M1_RREADY,
    input  logic [ADDR_WIDTH-1:0] slave0_addr1,
    input  logic [ADDR_WIDTH-1:0] slave0_addr2,
    input  logic [ADDR_WIDTH-1:0] slave1_addr1,
    input  logic [ADDR_WIDTH-1:0] slave1_addr2,
    input  logic                  S0_ARREADY,
    input  logic                  S0_RVALID,
    input  logic                  S0_RLAST,
    input  logic                  S1_ARREADY,
    input  logic                  S1_RVALID,
    input  logic                  S1_RLAST,
    output logic                  master_sel,
    output logic                  slave_sel,
    output logic                  ar_en,
    output logic                  r_en,
    output logic                  err_arready,
    output logic                  err_rvalid,
    output logic                  err_rlast,
    output logic                  busy,
    output logic [2:0]            fsm_state
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] DATA     = 3'd2;
    localparam logic [2:0] ERR_ADDR = 3'd3;
    localparam logic [2:0] ERR_DATA = 3'd4;

    logic [2:0]            state;
    logic                  master_q;
    logic                  slave_q;
    logic                  prio;
    logic [LEN_WIDTH-1:0]  beat_cnt;

    // Handshakes are plain AXI valid/ready: a transfer happens on a rising
    // edge where both sides are high; the owner is fixed until RLAST completes.
    logic                  winner;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  hit0;
    logic                  hit1;
    logic                  sel_arvalid;
    logic [LEN_WIDTH-1:0]  sel_arlen;
    logic                  sel_rready;
    logic                  sel_arready;
    logic                  sel_rvalid;
    logic                  sel_rlast;

    always_comb begin
        winner   = (M0_ARVALID && M1_ARVALID) ? prio : M1_ARVALID;
        win_addr = winner ? M1_ARADDR : M0_ARADDR;
        hit0     = (win_addr >= slave0_addr1) && (win_addr <= slave0_addr2);
        hit1     = (win_addr >= slave1_addr1) && (win_addr <= slave1_addr2);

        sel_arvalid = master_q ? M1_ARVALID : M0_ARVALID;
        sel_arlen   = master_q ? M1_ARLEN   : M0_ARLEN;
        sel_rready  = master_q ? M1_RREADY  : M0_RREADY;
        sel_arready = slave_q  ? S1_ARREADY : S0_ARREADY;
        sel_rvalid  = slave_q  ? S1_RVALID  : S0_RVALID;
        sel_rlast   = slave_q  ? S1_RLAST   : S0_RLAST;
    end

    always_ff @(posedge G_clk or negedge G_reset) begin
        if (!G_reset) begin
            state    <= IDLE;
            master_q <= 1'b0;
            slave_q  <= 1'b0;
            prio     <= RESET_PRIORITY;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (M0_ARVALID || M1_ARVALID) begin
                        master_q <= winner;
                        // S0 takes precedence where the two ranges overlap.
                        slave_q  <= !hit0 && hit1;
                        state    <= (hit0 || hit1) ? ADDR : ERR_ADDR;
                    end
                end
                ADDR: begin
                    if (sel_arvalid && sel_arready) state <= DATA;
                end
                DATA: begin
                    if (sel_rvalid && sel_rlast && sel_rready) begin
                        state <= IDLE;
                        prio  <= ~master_q;
                    end
                end
                ERR_ADDR: begin
                    beat_cnt <= sel_arlen;
                    state    <= ERR_DATA;
                end
                ERR_DATA: begin
                    if (sel_rready) begin
                        if (beat_cnt != '0) begin
                            beat_cnt <= beat_cnt - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            state <= IDLE;
                            prio  <= ~master_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded purely from registered state so reset clears them at once.
    always_comb begin
        busy        = (state != IDLE);
        master_sel  = busy && master_q;
        slave_sel   = busy && slave_q;
        ar_en       = (state == ADDR);
        r_en        = (state == DATA);
        err_arready = (state == ERR_ADDR);
        err_rvalid  = (state == ERR_DATA);
        err_rlast   = (state == ERR_DATA) && (beat_cnt == '0);
        fsm_state   = state;
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: grants are scoreboarded through exp_q,
// cycle-level strobes are checked inline after each clock edge.
module tb_axi_read_arbiter;

    logic        G_clk;
    logic        G_reset;
    logic        M0_ARVALID;
    logic [31:0] M0_ARADDR;
    logic [3:0]  M0_ARLEN;
    logic        M0_RREADY;
    logic        M1_ARVALID;
    logic [31:0] M1_ARADDR;
    logic [3:0]  M1_ARLEN;
    logic        M1_RREADY;
    logic [31:0] slave0_addr1;
    logic [31:0] slave0_addr2;
    logic [31:0] slave1_addr1;
    logic [31:0] slave1_addr2;
    logic        S0_ARREADY;
    logic        S0_RVALID;
    logic        S0_RLAST;
    logic        S1_ARREADY;
    logic        S1_RVALID;
    logic        S1_RLAST;
    logic        master_sel;
    logic        slave_sel;
    logic        ar_en;
    logic        r_en;
    logic        err_arready;
    logic        err_rvalid;
    logic        err_rlast;
    logic        busy;
    logic [2:0]  fsm_state;

    axi_read_arbiter #(.ADDR_WIDTH(32), .LEN_WIDTH(4), .RESET_PRIORITY(1'b0)) dut (
        .G_clk(G_clk), .G_reset(G_reset),
        .M0_ARVALID(M0_ARVALID), .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_RREADY(M0_RREADY),
        .M1_ARVALID(M1_ARVALID), .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_RREADY(M1_RREADY),
        .slave0_addr1(slave0_addr1), .slave0_addr2(slave0_addr2),
        .slave1_addr1(slave1_addr1), .slave1_addr2(slave1_addr2),
        .S0_ARREADY(S0_ARREADY), .S0_RVALID(S0_RVALID), .S0_RLAST(S0_RLAST),
        .S1_ARREADY(S1_ARREADY), .S1_RVALID(S1_RVALID), .S1_RLAST(S1_RLAST),
        .master_sel(master_sel), .slave_sel(slave_sel), .ar_en(ar_en), .r_en(r_en),
        .err_arready(err_arready), .err_rvalid(err_rvalid), .err_rlast(err_rlast),
        .busy(busy), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial G_clk = 1'b0;
    always #5 G_clk = ~G_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Grant record: {decode error, master, slave (0 on error)}
    logic [2:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic busy_prev = 1'b0;
    always @(negedge G_clk) begin
        logic [2:0] act;
        logic [2:0] exp;
        if (busy === 1'b1 && busy_prev === 1'b0) begin
            act = {err_arready, master_sel, err_arready ? 1'b0 : slave_sel};
            if (exp_q.size() == 0) begin
                check("unexpected_grant", {29'd0, act}, 32'hFFFF_FFFF);
            end else begin
                exp = exp_q.pop_front();
                check("grant", {29'd0, act}, {29'd0, exp});
            end
        end
        busy_prev <= busy;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge G_clk);
        #1;
    endtask

    task automatic clear_inputs();
        M0_ARVALID = 0; M0_ARADDR = 0; M0_ARLEN = 0; M0_RREADY = 0;
        M1_ARVALID = 0; M1_ARADDR = 0; M1_ARLEN = 0; M1_RREADY = 0;
        S0_ARREADY = 0; S0_RVALID = 0; S0_RLAST = 0;
        S1_ARREADY = 0; S1_RVALID = 0; S1_RLAST = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        G_reset = 1'b0;
        repeat (2) tick();
        G_reset = 1'b1;
        tick();
    endtask

    task automatic request(input int m, input logic [31:0] addr, input logic [3:0] len);
        if (m == 0) begin
            M0_ARVALID = 1; M0_ARADDR = addr; M0_ARLEN = len;
        end else begin
            M1_ARVALID = 1; M1_ARADDR = addr; M1_ARLEN = len;
        end
    endtask

    task automatic drop_arvalid(input int m);
        if (m == 0) M0_ARVALID = 0;
        else        M1_ARVALID = 0;
    endtask

    task automatic set_r(input int m, input int s, input logic rvalid, input logic rlast, input logic rready);
        if (s == 0) begin S0_RVALID = rvalid; S0_RLAST = rlast; end
        else        begin S1_RVALID = rvalid; S1_RLAST = rlast; end
        if (m == 0) M0_RREADY = rready;
        else        M1_RREADY = rready;
    endtask

    // Called with the DUT in ADDR for master m / slave s; completes a burst.
    task automatic serve(input int m, input int s, input int beats);
        check("ar_en_addr", {31'd0, ar_en}, 32'd1);
        if (s == 0) S0_ARREADY = 1; else S1_ARREADY = 1;
        tick();
        S0_ARREADY = 0; S1_ARREADY = 0;
        drop_arvalid(m);
        check("r_en_data", {31'd0, r_en}, 32'd1);
        check("ar_en_data", {31'd0, ar_en}, 32'd0);
        for (int b = 0; b < beats; b++) begin
            set_r(m, s, 1'b1, (b == beats - 1), 1'b1);
            tick();
            if (b != beats - 1) check("busy_midburst", {31'd0, busy}, 32'd1);
        end
        set_r(m, s, 1'b0, 1'b0, 1'b0);
        check("busy_after_rlast", {31'd0, busy}, 32'd0);
    endtask

    // Called with the DUT in ERR_ADDR; drains beats DECERR beats with RREADY held.
    task automatic err_serve(input int m, input int beats);
        check("err_arready", {31'd0, err_arready}, 32'd1);
        tick();
        drop_arvalid(m);
        check("err_arready_1cyc", {31'd0, err_arready}, 32'd0);
        set_r(m, 0, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < beats; b++) begin
            check("err_rvalid", {31'd0, err_rvalid}, 32'd1);
            check("err_rlast", {31'd0, err_rlast}, (b == beats - 1) ? 32'd1 : 32'd0);
            tick();
        end
        set_r(m, 0, 1'b0, 1'b0, 1'b0);
        check("busy_after_err", {31'd0, busy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] bnd_addr[8] = '{32'd1, 32'd5, 32'd10, 32'd15, 32'd0, 32'd6, 32'd9, 32'd16};
    logic [1:0]  bnd_exp[8]  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};

    initial begin
        slave0_addr1 = 32'd1;  slave0_addr2 = 32'd5;
        slave1_addr1 = 32'd10; slave1_addr2 = 32'd15;
        clear_inputs();
        G_reset = 1'b0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {29'd0, fsm_state}, 32'd0);
        check("rst_outs", {25'd0, master_sel, slave_sel, ar_en, r_en, err_arready, err_rvalid, err_rlast}, 32'd0);
        tick();
        G_reset = 1'b1;
        tick();

        // 1: single read M0 -> S1, two beats
        request(0, 32'd12, 4'd1);
        exp_q.push_back(3'b001);
        tick();
        check("t1_master", {31'd0, master_sel}, 32'd0);
        check("t1_slave", {31'd0, slave_sel}, 32'd1);
        serve(0, 1, 2);

        // 2: contention after reset, then again once prio has returned to M0
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            request(0, 32'd3, 4'd0);
            request(1, 32'd12, 4'd0);
            exp_q.push_back(3'b000);
            exp_q.push_back(3'b011);
            tick();
            serve(0, 0, 1);
            tick();
            check("t2_m1_master", {31'd0, master_sel}, 32'd1);
            serve(1, 1, 1);
        end

        // 3: decode error from M1, ARLEN=2, with a 2-cycle RREADY stall
        request(1, 32'd7, 4'd2);
        exp_q.push_back(3'b110);
        tick();
        check("t3_err_arready", {31'd0, err_arready}, 32'd1);
        tick();
        drop_arvalid(1);
        check("t3_err_arready_1cyc", {31'd0, err_arready}, 32'd0);
        M1_RREADY = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t3_stall_rvalid", {31'd0, err_rvalid}, 32'd1);
            check("t3_stall_rlast", {31'd0, err_rlast}, 32'd0);
        end
        M1_RREADY = 1;
        tick();
        check("t3_beat2_rlast", {31'd0, err_rlast}, 32'd0);
        tick();
        check("t3_beat3_rlast", {31'd0, err_rlast}, 32'd1);
        check("t3_beat3_rvalid", {31'd0, err_rvalid}, 32'd1);
        tick();
        M1_RREADY = 0;
        check("t3_idle", {31'd0, busy}, 32'd0);

        // 4: decode boundaries
        for (int i = 0; i < 8; i++) begin
            request(0, bnd_addr[i], 4'd0);
            exp_q.push_back(bnd_exp[i] == 2'd2 ? 3'b100 : {2'b00, bnd_exp[i][0]});
            tick();
            if (bnd_exp[i] == 2'd2) err_serve(0, 1);
            else serve(0, int'(bnd_exp[i]), 1);
        end

        // 5: RLAST held against RREADY=0 for 3 cycles
        request(0, 32'd2, 4'd0);
        exp_q.push_back(3'b000);
        tick();
        S0_ARREADY = 1;
        tick();
        S0_ARREADY = 0;
        drop_arvalid(0);
        set_r(0, 0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_hold_r_en", {31'd0, r_en}, 32'd1);
        end
        M0_RREADY = 1;
        tick();
        set_r(0, 0, 1'b0, 1'b0, 1'b0);
        check("t5_done", {31'd0, busy}, 32'd0);

        // 6: asynchronous reset in DATA, then RESET_PRIORITY decides contention
        request(1, 32'd11, 4'd0);
        exp_q.push_back(3'b011);
        tick();
        S1_ARREADY = 1;
        tick();
        S1_ARREADY = 0;
        check("t6_in_data", {31'd0, r_en}, 32'd1);
        #2;
        G_reset = 1'b0;
        #1;
        check("t6_async_outs", {24'd0, busy, master_sel, slave_sel, ar_en, r_en, err_arready, err_rvalid, err_rlast}, 32'd0);
        clear_inputs();
        tick();
        G_reset = 1'b1;
        tick();
        request(0, 32'd3, 4'd0);
        request(1, 32'd12, 4'd0);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b011);
        tick();
        check("t6_prio_m0", {31'd0, master_sel}, 32'd0);
        serve(0, 0, 1);
        tick();
        serve(1, 1, 1);

        @(negedge G_clk);
        @(negedge G_clk);
        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
